// File: rtl/env_ar_vca.sv
// Gate-triggered attack/hold/release envelope generator with a built-in VCA.
// State advances once per rising edge of sample_clk; outputs settle three clk cycles later.
module env_ar_vca #(
    parameter int W        = 16,
    parameter int GATE_ON  = 8000,
    parameter int GATE_OFF = 4000,
    parameter int TRIG_LEN = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    input  logic [7:0]          jack
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ATTACK  = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int                  TW      = $clog2(TRIG_LEN + 1);
    localparam int                  PW      = W + 16;
    localparam logic [23:0]         ACC_MAX = 24'hFFFFFF;
    localparam logic signed [W-1:0] TH_ON   = W'(GATE_ON);
    localparam logic signed [W-1:0] TH_OFF  = W'(GATE_OFF);
    localparam logic signed [W-1:0] FULL    = W'(32767);

    // Negative rates clamp to the slowest step; the +1 keeps every step non-zero.
    function automatic logic [15:0] rate_step(input logic signed [W-1:0] r);
        logic [15:0] s;
        if (r < 0)
            s = 16'd0;
        else if (r > FULL)
            s = 16'd32767;
        else
            s = {1'b0, r[14:0]};
        return s + 16'd1;
    endfunction

    function automatic logic signed [W-1:0] vca_scale(input logic signed [PW-1:0] p);
        return p[W+14:15];
    endfunction

    logic                unused_jack;
    logic                sclk_q, armed_q, stb;
    logic [1:0]          state_q, state_d;
    logic [23:0]         acc_q, acc_d, acc_sat, acc_dn;
    logic [24:0]         acc_up;
    logic                gate_q, gate_n, rise, fall, do_attack, do_release;
    logic [TW-1:0]       trig_q, trig_d;
    logic [15:0]         step_a, step_r;
    logic signed [W-1:0] in3_p0_q;
    logic signed [PW-1:0] in3_ext, env_ext;
    logic [14:0]         env_p1_q;
    logic signed [PW-1:0] prod_p1_q;
    logic                gate_p1_q, trig_p1_q;
    logic signed [W-1:0] out0_p2_q, out1_p2_q, out2_p2_q, out3_p2_q;

    assign unused_jack = ^jack[7:1];

    // armed_q insists on a low level after reset, so a high sample_clk at release is no edge.
    assign stb = sample_clk & ~sclk_q & armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sclk_q <= sample_clk;
            if (!sample_clk)
                armed_q <= 1'b1;
        end
    end

    always_comb begin
        gate_n  = jack[0] & (gate_q ? (sample_in0 >= TH_OFF) : (sample_in0 >= TH_ON));
        rise    = gate_n & ~gate_q;
        fall    = ~gate_n & gate_q;
        step_a  = rate_step(sample_in1);
        step_r  = rate_step(sample_in2);
        acc_up  = {1'b0, acc_q} + {9'd0, step_a};
        acc_sat = acc_up[24] ? ACC_MAX : acc_up[23:0];
        acc_dn  = (acc_q > {8'd0, step_r}) ? (acc_q - {8'd0, step_r}) : 24'd0;

        state_d    = state_q;
        acc_d      = acc_q;
        trig_d     = (trig_q != '0) ? (trig_q - TW'(1)) : trig_q;
        do_attack  = 1'b0;
        do_release = 1'b0;

        // Gate events win over saturation/floor; a new state acts on the sample that enters it,
        // except an attack cut short, which freezes the level for that sample.
        case (state_q)
            ST_IDLE: begin
                acc_d     = 24'd0;
                do_attack = rise;
            end
            ST_ATTACK: begin
                if (fall)
                    state_d = ST_RELEASE;
                else
                    do_attack = 1'b1;
            end
            ST_HOLD: begin
                acc_d      = ACC_MAX;
                do_release = fall;
            end
            default: begin
                do_attack  = rise;
                do_release = ~rise;
            end
        endcase

        if (do_attack) begin
            acc_d   = acc_sat;
            state_d = ST_ATTACK;
            if (acc_sat == ACC_MAX) begin
                state_d = ST_HOLD;
                trig_d  = TW'(TRIG_LEN);
            end
        end
        if (do_release) begin
            acc_d   = acc_dn;
            state_d = (acc_dn == 24'd0) ? ST_IDLE : ST_RELEASE;
        end
    end

    // S0: state update on the strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= 24'd0;
            gate_q   <= 1'b0;
            trig_q   <= '0;
            in3_p0_q <= '0;
        end else if (stb) begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            gate_q   <= gate_n;
            trig_q   <= trig_d;
            in3_p0_q <= sample_in3;
        end
    end

    assign in3_ext = PW'(in3_p0_q);
    assign env_ext = PW'($signed({1'b0, acc_q[23:9]}));

    // S1: envelope level and VCA product
    always_ff @(posedge clk) begin
        if (rst) begin
            env_p1_q  <= '0;
            prod_p1_q <= '0;
            gate_p1_q <= 1'b0;
            trig_p1_q <= 1'b0;
        end else begin
            env_p1_q  <= acc_q[23:9];
            prod_p1_q <= in3_ext * env_ext;
            gate_p1_q <= gate_q;
            trig_p1_q <= (trig_q != '0);
        end
    end

    // S2: output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_p2_q <= '0;
            out1_p2_q <= '0;
            out2_p2_q <= '0;
            out3_p2_q <= '0;
        end else begin
            out0_p2_q <= W'({1'b0, env_p1_q});
            out1_p2_q <= vca_scale(prod_p1_q);
            out2_p2_q <= gate_p1_q ? FULL : '0;
            out3_p2_q <= trig_p1_q ? FULL : '0;
        end
    end

    assign sample_out0 = out0_p2_q;
    assign sample_out1 = out1_p2_q;
    assign sample_out2 = out2_p2_q;
    assign sample_out3 = out3_p2_q;
endmodule

// File: tb/tb_env_ar_vca.sv
// Scoreboard bench for env_ar_vca: stimulus pushes expected outputs, a monitor pops and compares.
module tb_env_ar_vca;
    logic               clk = 1'b0;
    logic               rst;
    logic               sample_clk;
    logic signed [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic [7:0]         jack;

    typedef struct {
        int tag;
        int idx;
        int e0;
        int e1;
        int e2;
        int e3;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;
    bit   mon_prev = 1'b0;

    env_ar_vca dut (
        .clk        (clk),
        .rst        (rst),
        .sample_clk (sample_clk),
        .sample_in0 (sample_in0),
        .sample_in1 (sample_in1),
        .sample_in2 (sample_in2),
        .sample_in3 (sample_in3),
        .sample_out0(sample_out0),
        .sample_out1(sample_out1),
        .sample_out2(sample_out2),
        .sample_out3(sample_out3),
        .jack       (jack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag, input int idx,
                       input logic signed [15:0] act, input int exp);
        logic signed [15:0] e16;
        e16 = 16'(exp);
        checks++;
        if (act !== e16) begin
            errors++;
            $display("FAIL %s t%0d s%0d: got %0d, expected %0d", nm, tag, idx, act, e16);
        end
    endtask

    task automatic chk4(input string pfx, input exp_t e);
        chk({pfx, "out0"}, e.tag, e.idx, sample_out0, e.e0);
        chk({pfx, "out1"}, e.tag, e.idx, sample_out1, e.e1);
        chk({pfx, "out2"}, e.tag, e.idx, sample_out2, e.e2);
        chk({pfx, "out3"}, e.tag, e.idx, sample_out3, e.e3);
    endtask

    // Monitor: on each sample_clk rise, outputs must still hold at +2 clk and update at +3 clk.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rst && sample_clk && !mon_prev) begin
                @(posedge clk); #1;
                chk4("hold_", last);
                @(posedge clk); #1;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got 0 entries, expected 1");
                end else begin
                    e = q.pop_front();
                    chk4("", e);
                    last = e;
                end
            end
            mon_prev = sample_clk;
        end
    end

    task automatic samp(input int a0, input int a1, input int a2, input int a3,
                        input int e0, input int e1, input int e2, input int e3,
                        input int tag, input int idx);
        exp_t e;
        e = '{tag, idx, e0, e1, e2, e3};
        q.push_back(e);
        sample_clk = 1'b0;
        sample_in0 = 16'(a0);
        sample_in1 = 16'(a1);
        sample_in2 = 16'(a2);
        sample_in3 = 16'(a3);
        repeat (4) @(negedge clk);
        sample_clk = 1'b1;
        repeat (4) @(negedge clk);
        sample_clk = 1'b0;
    endtask

    task automatic do_reset(input int n, input bit toggle, input int tag);
        exp_t z;
        z = '{tag, 0, 0, 0, 0, 0};
        q.delete();
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            z.idx = i;
            chk4("rst_", z);
            @(negedge clk);
            if (toggle)
                sample_clk = ~sample_clk;
        end
        last = '{tag, 0, 0, 0, 0, 0};
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int e0;
        int e3;
        rst        = 1'b1;
        sample_clk = 1'b0;
        sample_in0 = '0;
        sample_in1 = '0;
        sample_in2 = '0;
        sample_in3 = '0;
        jack       = 8'h00;
        @(negedge clk);

        // Reset with sample_clk toggling; released while sample_clk is high.
        do_reset(5, 1'b1, 1);
        jack = 8'hFF;
        for (int k = 1; k <= 10; k++)
            samp(0, 0, 0, 0, 0, 0, 0, 0, 1, k);

        // Full attack to HOLD at fastest rate.
        for (int k = 1; k <= 600; k++) begin
            e0 = (k < 512) ? 64 * k : 32767;
            e3 = (k >= 512 && k < 512 + 48) ? 32767 : 0;
            samp(10000, 32767, 32767, 0, e0, 0, 32767, e3, 2, k);
        end
        // VCA in HOLD.
        samp(10000, 32767, 32767, 16384,  32767, 16383,  32767, 0, 5, 1);
        samp(10000, 32767, 32767, -32768, 32767, -32767, 32767, 0, 5, 2);
        samp(10000, 32767, 32767, 0,      32767, 0,      32767, 0, 5, 3);
        // Release to IDLE.
        for (int j = 1; j <= 520; j++) begin
            e0 = (j < 512) ? 32767 - 64 * j : 0;
            samp(0, 32767, 32767, 0, e0, 0, 0, 0, 2, 1000 + j);
        end
        samp(0, 32767, 32767, 16384, 0, 0, 0, 0, 5, 4);

        // Hysteresis, then the same sequence with jack[0] cleared.
        do_reset(2, 1'b0, 3);
        jack = 8'hFF;
        samp(5000, 32767, 32767, 0, 0,   0, 0,     0, 3, 1);
        samp(8000, 32767, 32767, 0, 64,  0, 32767, 0, 3, 2);
        samp(5000, 32767, 32767, 0, 128, 0, 32767, 0, 3, 3);
        samp(3999, 32767, 32767, 0, 128, 0, 0,     0, 3, 4);
        samp(0,    32767, 32767, 0, 64,  0, 0,     0, 3, 5);
        samp(0,    32767, 32767, 0, 0,   0, 0,     0, 3, 6);
        samp(0,    32767, 32767, 0, 0,   0, 0,     0, 3, 7);
        jack = 8'hFE;
        samp(5000, 32767, 32767, 0, 0, 0, 0, 0, 3, 11);
        samp(8000, 32767, 32767, 0, 0, 0, 0, 0, 3, 12);
        samp(5000, 32767, 32767, 0, 0, 0, 0, 0, 3, 13);
        samp(3999, 32767, 32767, 0, 0, 0, 0, 0, 3, 14);

        // Retrigger during release resumes from the current level.
        do_reset(2, 1'b0, 4);
        jack = 8'hFF;
        for (int k = 1; k <= 560; k++) begin
            e0 = (k < 512) ? 64 * k : 32767;
            e3 = (k >= 512 && k < 512 + 48) ? 32767 : 0;
            samp(10000, 32767, 32767, 0, e0, 0, 32767, e3, 4, k);
        end
        for (int j = 1; j <= 100; j++)
            samp(0, 32767, 32767, 0, 32767 - 64 * j, 0, 0, 0, 4, 1000 + j);
        for (int m = 1; m <= 110; m++) begin
            acc = 16777215 - 100 * 32768 + m * 32768;
            if (acc > 16777215)
                acc = 16777215;
            e3 = (m >= 100 && m < 100 + 48) ? 32767 : 0;
            samp(10000, 32767, 32767, 0, acc / 512, 0, 32767, e3, 4, 2000 + m);
        end

        // Negative attack rate clamps to step 1.
        do_reset(2, 1'b0, 6);
        for (int k = 1; k <= 514; k++)
            samp(10000, -1000, 32767, 0, k / 512, 0, 32767, 0, 6, k);

        // Reset mid-attack clears outputs at once and restarts from IDLE.
        do_reset(2, 1'b0, 7);
        samp(10000, 32767, 32767, 0, 64,  0, 32767, 0, 7, 1);
        samp(10000, 32767, 32767, 0, 128, 0, 32767, 0, 7, 2);

        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
